// File: rtl/btn_debounce.sv
// Purpose: debounce a raw push-button pin into a clean level plus PRESS/RELEASE/LONG pulses.
// Latency: level and PRESS/RELEASE commit DB_CYCLES+2 edges after the pin changes; LONG fires LONG_CYCLES edges after PRESS.
// Backpressure: none; the events are single-cycle pulses and are not held for the consumer.
//
// Ports:
//   CLK       clock, all logic on posedge
//   RST       synchronous active-high reset
//   BTN       raw asynchronous button pin, active-high
//   BTN_LEVEL debounced button level
//   PRESS     one-cycle pulse when BTN_LEVEL rises
//   RELEASE   one-cycle pulse when BTN_LEVEL falls
//   LONG      one-cycle pulse once a press has been held LONG_CYCLES cycles (at most one per press)
//   HELD      high from LONG until the matching RELEASE
module btn_debounce #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic BTN_LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic HELD
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

  localparam logic [1:0] S_RELEASED  = 2'd0;
  localparam logic [1:0] S_ARMING    = 2'd1;
  localparam logic [1:0] S_PRESSED   = 2'd2;
  localparam logic [1:0] S_DISARMING = 2'd3;

  logic              sync0;
  logic              sync1;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [LONG_W-1:0] long_cnt;

  logic differ;
  logic db_done;
  logic press_commit;
  logic release_commit;
  logic long_hit;

  // The committed level is encoded in the state: DISARMING is still "pressed"
  // until the release commits, ARMING is still "released" until the press commits.
  assign BTN_LEVEL = (state == S_PRESSED) || (state == S_DISARMING);

  assign differ         = (sync1 != BTN_LEVEL);
  assign db_done        = differ && (db_cnt == DB_MAX);
  assign press_commit   = db_done && sync1;
  assign release_commit = db_done && !sync1;

  // A release committing on the same edge as the long threshold suppresses LONG.
  assign long_hit = BTN_LEVEL && !HELD && (long_cnt == LONG_MAX) && !release_commit;

  always_comb begin
    state_nxt = state;
    if (!differ) begin
      // Bounce returned to the stable level: drop back, count discarded.
      state_nxt = BTN_LEVEL ? S_PRESSED : S_RELEASED;
    end else if (db_done) begin
      state_nxt = sync1 ? S_PRESSED : S_RELEASED;
    end else begin
      state_nxt = sync1 ? S_ARMING : S_DISARMING;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      state    <= S_RELEASED;
      db_cnt   <= '0;
      long_cnt <= '0;
      PRESS    <= 1'b0;
      RELEASE  <= 1'b0;
      LONG     <= 1'b0;
      HELD     <= 1'b0;
    end else begin
      sync0   <= BTN;
      sync1   <= sync0;
      state   <= state_nxt;
      PRESS   <= press_commit;
      RELEASE <= release_commit;
      LONG    <= long_hit;

      if (!differ || db_done) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // Counts through DISARMING too; parks at the threshold instead of wrapping.
      if (press_commit || release_commit) begin
        long_cnt <= '0;
      end else if (BTN_LEVEL && !HELD && (long_cnt != LONG_MAX)) begin
        long_cnt <= long_cnt + 1'b1;
      end

      if (release_commit) begin
        HELD <= 1'b0;
      end else if (long_hit) begin
        HELD <= 1'b1;
      end
    end
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Counter-based push-button debouncer with press, release and long-press event detection. It sits directly upstream of the LED toggle logic. It turns the raw, bouncing BTN pin into a clean stable level plus single-cycle PRESS, RELEASE and LONG pulses. Downstream logic consumes PRESS in place of a raw edge detect.

## Interface
- DB_CYCLES, 1_000_000: consecutive cycles the synchronized input must differ from the stable level before the level flips (10 ms at 100 MHz). Must be >= 2.
- LONG_CYCLES, 100_000_000: cycles after PRESS before LONG fires (1 s at 100 MHz). Must be > DB_CYCLES.
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset, synchronous and active-high.
- BTN  in  1  raw asynchronous button pin, active-high.
- BTN_LEVEL  out  1  debounced button level.
- PRESS  out  1  one-cycle pulse when BTN_LEVEL rises.
- RELEASE  out  1  one-cycle pulse when BTN_LEVEL falls.
- LONG  out  1  one-cycle pulse when a press has been held LONG_CYCLES cycles. At most one per press.
- HELD  out  1  high from LONG until the matching RELEASE.

## Operation
- BTN passes through a two-flop synchronizer, sync0 then sync1. Only sync1 is used downstream.
- The FSM has four states:
  - RELEASED: stable low.
  - ARMING: sync1 high, counting.
  - PRESSED: stable high.
  - DISARMING: sync1 low while pressed, counting.
- Debounce counter db_cnt is $clog2(DB_CYCLES) bits wide. On each edge:
  - If sync1 == BTN_LEVEL: db_cnt <= 0. State returns to RELEASED or PRESSED (bounce discarded).
  - Else if db_cnt == DB_CYCLES-1: BTN_LEVEL <= sync1 and db_cnt <= 0. State goes to PRESSED or RELEASED. PRESS or RELEASE pulses on this edge.
  - Else: db_cnt <= db_cnt+1. State is ARMING or DISARMING.
- Long counter long_cnt is $clog2(LONG_CYCLES) bits wide:
  - Cleared on the PRESS edge.
  - Increments every cycle BTN_LEVEL = 1 and HELD = 0, including cycles spent in DISARMING.
  - When long_cnt == LONG_CYCLES-1, LONG pulses and HELD <= 1. long_cnt then stops; it never wraps.
- RELEASE clears HELD and long_cnt on the same edge.
- If the release commit and the long threshold fall on the same edge, release wins: RELEASE pulses, LONG does not, HELD stays 0.
- PRESS, RELEASE and LONG are registered. They are never high for more than one consecutive cycle. PRESS and RELEASE are never high together.
- A bounce that returns to the stable level before DB_CYCLES consecutive differing cycles produces no event, and its count is discarded completely.

## Timing
- Reset values: BTN_LEVEL, PRESS, RELEASE, LONG and HELD are 0. sync0, sync1, db_cnt and long_cnt are 0. State is RELEASED.
- RST asserted mid-press aborts everything the next edge, with no RELEASE pulse.
- If BTN is held high across reset release, a normal PRESS follows after the full latency.
- Latency: BTN first sampled high at edge 1 gives sync1 = 1 after edge 2. BTN_LEVEL and PRESS assert on edge DB_CYCLES+2, provided BTN stays high.
- Release latency is symmetric: DB_CYCLES+2 edges after BTN is first sampled low.
- LONG asserts exactly LONG_CYCLES edges after the PRESS edge.
- Input glitches shorter than one clock may be missed by the synchronizer. This is acceptable.

## Test plan
Use DB_CYCLES=4 and LONG_CYCLES=20 for all scenarios.
- Clean press: BTN 0→1 sampled at edge 1 and held → BTN_LEVEL and PRESS high at edge 6. PRESS low at edge 7. No other pulses.
- Bounce rejection: BTN toggles high 3 cycles, low 1, high 3, low 1, then stays low → BTN_LEVEL stays 0 and no PRESS ever occurs.
- Bouncy press then clean release: bounce pattern followed by steady high → exactly one PRESS. BTN low held 4+ synced cycles → exactly one RELEASE, 6 edges after the first low sample.
- Long press: hold BTN 30 cycles after PRESS → LONG pulses once, 20 edges after PRESS. HELD stays 1 until RELEASE, then returns to 0. No second LONG.
- Release/long collision: time the release commit so it lands on edge PRESS+20 → RELEASE=1 and LONG=0 on that edge, HELD=0.
- Reset mid-press: assert RST while BTN_LEVEL=1 and HELD=1 → all outputs 0 at the next edge, no RELEASE. With BTN still high after RST drops, PRESS fires 6 edges later.
